ps2mouse_tracker: RTL

//  Parametrised successor to the PS/2 mouse position accumulator. Consumes raw bytes from
//  the PS/2 read function module and assembles 3-byte packets, or 4-byte packets with

---
 rtl/ps2mouse_tracker.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ps2mouse_tracker.sv
// PS/2 mouse packet assembler: builds 3/4-byte packets from raw bytes and tracks a
// clamped cursor position, wheel accumulator, button state, click flags and error count.
module ps2mouse_tracker #(
  parameter int unsigned POS_W       = 16,
  parameter int unsigned X_MAX       = 639,
  parameter int unsigned Y_MAX       = 479,
  parameter int unsigned WHEEL_EN    = 0,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned Y_INVERT    = 1,
  parameter int unsigned TIMEOUT     = 50000
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             iByteEn,
  input  logic [7:0]       iByte,
  input  logic             iClr,
  input  logic             iAck,
  output logic             oTrig,
  output logic [POS_W-1:0] Xpos,
  output logic [POS_W-1:0] Ypos,
  output logic [7:0]       Wheel,
  output logic [7:0]       key_down,
  output logic [2:0]       key_click,
  output logic [7:0]       oErrCnt
);

  localparam int unsigned SW    = POS_W + SCALE_SHIFT + 2;
  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [POS_W-1:0] X_CTR  = POS_W'(X_MAX / 2);
  localparam logic [POS_W-1:0] Y_CTR  = POS_W'(Y_MAX / 2);
  localparam logic [SW-1:0]    X_LIM  = SW'(X_MAX);
  localparam logic [SW-1:0]    Y_LIM  = SW'(Y_MAX);
  localparam logic [CNT_W-1:0] TO_END = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_B1     = 3'd1;
  localparam logic [2:0] S_B2     = 3'd2;
  localparam logic [2:0] S_B3     = 3'd3;
  localparam logic [2:0] S_COMMIT = 3'd4;

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt;
  // header byte without its always-one bit: {yovf, xovf, ysgn, xsgn, btn[2:0]}
  logic [6:0]       hdr;
  logic [7:0]       b1, b2;

  logic             start_c, commit_c, drop_c, tout_c, in_pkt_c;
  logic [7:0]       b2_eff_c;
  logic [8:0]       dx9_c, dy9_c;
  logic [SW-1:0]    dx_c, dy_c, sx_c, sy_c;
  logic [POS_W-1:0] nx_c, ny_c;
  logic [7:0]       wdelta_c;
  logic [2:0]       rise_c;

  function automatic logic [POS_W-1:0] clamp(input logic [SW-1:0] v, input logic [SW-1:0] lim);
    if (v[SW-1])     clamp = '0;
    else if (v > lim) clamp = lim[POS_W-1:0];
    else              clamp = v[POS_W-1:0];
  endfunction

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next state and per-cycle event strobes
  always_comb begin
    state_n  = state;
    start_c  = 1'b0;
    commit_c = 1'b0;
    drop_c   = 1'b0;
    tout_c   = 1'b0;
    in_pkt_c = (state == S_B1) || (state == S_B2) || (state == S_B3);
    case (state)
      S_IDLE, S_COMMIT: begin
        state_n = S_IDLE;
        if (iByteEn) begin
          if (iByte[3]) begin
            state_n = S_B1;
            start_c = 1'b1;
          end else begin
            drop_c = 1'b1;
          end
        end
      end
      S_B1: begin
        if (iByteEn) state_n = S_B2;
      end
      S_B2: begin
        if (iByteEn) begin
          if (WHEEL_EN != 0) begin
            state_n = S_B3;
          end else begin
            state_n  = S_COMMIT;
            commit_c = 1'b1;
          end
        end
      end
      S_B3: begin
        if (iByteEn) begin
          state_n  = S_COMMIT;
          commit_c = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
    if (in_pkt_c && !iByteEn && (cnt == TO_END)) begin
      state_n = S_IDLE;
      tout_c  = 1'b1;
    end
  end

  // Packet arithmetic: the final byte is consumed directly from iByte
  always_comb begin
    b2_eff_c = (WHEEL_EN != 0) ? b2 : iByte;
    dx9_c    = hdr[5] ? 9'd0 : {hdr[3], b1};
    dy9_c    = hdr[6] ? 9'd0 : {hdr[4], b2_eff_c};
    dx_c     = {{(SW-9){dx9_c[8]}}, dx9_c} << SCALE_SHIFT;
    dy_c     = {{(SW-9){dy9_c[8]}}, dy9_c} << SCALE_SHIFT;
    if (Y_INVERT != 0) dy_c = SW'(0) - dy_c;
    sx_c     = {{(SW-POS_W){1'b0}}, Xpos} + dx_c;
    sy_c     = {{(SW-POS_W){1'b0}}, Ypos} + dy_c;
    nx_c     = clamp(sx_c, X_LIM);
    ny_c     = clamp(sy_c, Y_LIM);
    wdelta_c = {{4{iByte[3]}}, iByte[3:0]};
    rise_c   = commit_c ? (hdr[2:0] & ~key_down[2:0]) : 3'b000;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt <= '0;
      hdr <= '0;
      b1  <= '0;
      b2  <= '0;
    end else begin
      if (in_pkt_c && !iByteEn && !tout_c) cnt <= cnt + CNT_W'(1);
      else                                 cnt <= '0;
      if (start_c)                    hdr <= {iByte[7:4], iByte[2:0]};
      if (iByteEn && state == S_B1)   b1  <= iByte;
      if (iByteEn && state == S_B2)   b2  <= iByte;
    end
  end

  // Registered outputs; iClr overrides the packet for position and wheel only
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      oTrig     <= 1'b0;
      Xpos      <= X_CTR;
      Ypos      <= Y_CTR;
      Wheel     <= '0;
      key_down  <= '0;
      key_click <= '0;
      oErrCnt   <= '0;
    end else begin
      oTrig <= commit_c;
      if (iClr) begin
        Xpos  <= X_CTR;
        Ypos  <= Y_CTR;
        Wheel <= '0;
      end else if (commit_c) begin
        Xpos <= nx_c;
        Ypos <= ny_c;
        if (WHEEL_EN != 0) Wheel <= Wheel + wdelta_c;
      end
      if (commit_c) key_down <= {5'b00000, hdr[2:0]};
      key_click <= (key_click & {3{~iAck}}) | rise_c;
      if ((drop_c || tout_c) && (oErrCnt != 8'hFF)) oErrCnt <= oErrCnt + 8'd1;
    end
  end

endmodule
